// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline memory-access stage.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef logic [1:0] exc_code_t;

    localparam exc_code_t EXC_NONE     = 2'd0;
    localparam exc_code_t EXC_OVERFLOW = 2'd1;
    localparam exc_code_t EXC_MISALIGN = 2'd2;
    localparam exc_code_t EXC_BUS      = 2'd3;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Overflow outranks misalignment, which outranks a bus error.
    function automatic exc_code_t exc_encode(input logic ov, input logic mis, input logic bus);
        if (ov)  return EXC_OVERFLOW;
        if (mis) return EXC_MISALIGN;
        if (bus) return EXC_BUS;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory handshake FSM with transaction timeout and load-data hold register.
module dmem_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_load_i,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        req_o,
    output logic        done_o,
    output logic        bus_err_o,
    output logic [31:0] rdata_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             expired;

    // Last allowed cycle in REQ/RESP; a handshake on that cycle still wins.
    assign expired = (cnt_q >= CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = REQ;
                    cnt_d     = '0;
                    bus_err_d = 1'b0;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_ready_i) begin
                    state_d = is_load_i ? RESP : DONE;
                end else if (expired) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            RESP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (dmem_rvalid_i) begin
                    rdata_d = dmem_rdata_i;
                    state_d = DONE;
                end else if (expired) begin
                    state_d   = DONE;
                    bus_err_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req_o     = (state_q == REQ);
    assign done_o    = (state_q == DONE);
    assign bus_err_o = bus_err_q;
    assign rdata_o   = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: exception decode, pipeline stall and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_MEM_valid,
    input  logic [31:0] i_MEM_data_ALUOut,
    input  logic        i_MEM_data_Overflow,
    input  logic [31:0] i_MEM_data_RTData,
    input  logic        i_MEM_ctrl_MemRead,
    input  logic        i_MEM_ctrl_MemWrite,
    input  logic [4:0]  i_WB_data_RegAddrW,
    input  logic        i_WB_ctrl_Mem2Reg,
    input  logic        i_WB_ctrl_RegWrite,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [29:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_WB_valid,
    output logic [31:0] o_WB_data_ALUOut,
    output logic [31:0] o_WB_data_MemData,
    output logic [4:0]  o_WB_data_RegAddrW,
    output logic        o_WB_ctrl_Mem2Reg,
    output logic        o_WB_ctrl_RegWrite,
    output logic        o_exc_overflow,
    output logic        o_exc_misalign,
    output logic        o_exc_bus
);

    logic        memop, exc_ov, exc_mis, clean_memop;
    logic        ctrl_done, ctrl_bus_err;
    logic [31:0] ctrl_rdata;
    exc_code_t   exc_code;

    assign memop       = i_MEM_valid & (i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite);
    assign exc_ov      = i_MEM_valid & i_MEM_data_Overflow;
    assign exc_mis     = memop & (i_MEM_data_ALUOut[1:0] != 2'b00);
    assign clean_memop = memop & ~exc_ov & ~exc_mis;
    assign o_stall     = clean_memop & ~ctrl_done;
    // Bus error only counts while the transaction that raised it sits in DONE.
    assign exc_code    = exc_encode(exc_ov, exc_mis, clean_memop & ctrl_bus_err);

    assign o_dmem_addr  = i_MEM_data_ALUOut[31:2];
    assign o_dmem_we    = i_MEM_ctrl_MemWrite & ~i_MEM_ctrl_MemRead;
    assign o_dmem_wdata = i_MEM_data_RTData;

    dmem_ctrl #(.TIMEOUT(TIMEOUT)) u_dmem_ctrl (
        .clk           (clk),
        .rst           (rst),
        .start_i       (clean_memop),
        .is_load_i     (i_MEM_ctrl_MemRead),
        .dmem_ready_i  (i_dmem_ready),
        .dmem_rvalid_i (i_dmem_rvalid),
        .dmem_rdata_i  (i_dmem_rdata),
        .req_o         (o_dmem_req),
        .done_o        (ctrl_done),
        .bus_err_o     (ctrl_bus_err),
        .rdata_o       (ctrl_rdata)
    );

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_mem_q, wb_mem_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_m2r_q, wb_m2r_d;
    logic        wb_rw_q, wb_rw_d;
    exc_code_t   wb_exc_q, wb_exc_d;

    always_comb begin
        wb_valid_d = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_mem_d   = wb_mem_q;
        wb_rd_d    = wb_rd_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = 1'b0;
        wb_exc_d   = EXC_NONE;
        if (!o_stall) begin
            wb_valid_d = i_MEM_valid;
            wb_alu_d   = i_MEM_data_ALUOut;
            wb_mem_d   = ctrl_rdata;
            wb_rd_d    = i_WB_data_RegAddrW;
            wb_m2r_d   = i_WB_ctrl_Mem2Reg;
            wb_rw_d    = i_WB_ctrl_RegWrite & (exc_code == EXC_NONE);
            wb_exc_d   = exc_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_rd_q    <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_exc_q   <= EXC_NONE;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_rd_q    <= wb_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

    assign o_WB_valid         = wb_valid_q;
    assign o_WB_data_ALUOut   = wb_alu_q;
    assign o_WB_data_MemData  = wb_mem_q;
    assign o_WB_data_RegAddrW = wb_rd_q;
    assign o_WB_ctrl_Mem2Reg  = wb_m2r_q;
    assign o_WB_ctrl_RegWrite = wb_rw_q;
    assign o_exc_overflow     = (wb_exc_q == EXC_OVERFLOW);
    assign o_exc_misalign     = (wb_exc_q == EXC_MISALIGN);
    assign o_exc_bus          = (wb_exc_q == EXC_BUS);

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage, built with a 4-cycle bus timeout.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_MEM_valid;
    logic [31:0] i_MEM_data_ALUOut;
    logic        i_MEM_data_Overflow;
    logic [31:0] i_MEM_data_RTData;
    logic        i_MEM_ctrl_MemRead;
    logic        i_MEM_ctrl_MemWrite;
    logic [4:0]  i_WB_data_RegAddrW;
    logic        i_WB_ctrl_Mem2Reg;
    logic        i_WB_ctrl_RegWrite;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [29:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ready;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_WB_valid;
    logic [31:0] o_WB_data_ALUOut;
    logic [31:0] o_WB_data_MemData;
    logic [4:0]  o_WB_data_RegAddrW;
    logic        o_WB_ctrl_Mem2Reg;
    logic        o_WB_ctrl_RegWrite;
    logic        o_exc_overflow;
    logic        o_exc_misalign;
    logic        o_exc_bus;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_MEM_valid         (i_MEM_valid),
        .i_MEM_data_ALUOut   (i_MEM_data_ALUOut),
        .i_MEM_data_Overflow (i_MEM_data_Overflow),
        .i_MEM_data_RTData   (i_MEM_data_RTData),
        .i_MEM_ctrl_MemRead  (i_MEM_ctrl_MemRead),
        .i_MEM_ctrl_MemWrite (i_MEM_ctrl_MemWrite),
        .i_WB_data_RegAddrW  (i_WB_data_RegAddrW),
        .i_WB_ctrl_Mem2Reg   (i_WB_ctrl_Mem2Reg),
        .i_WB_ctrl_RegWrite  (i_WB_ctrl_RegWrite),
        .o_stall             (o_stall),
        .o_dmem_req          (o_dmem_req),
        .o_dmem_we           (o_dmem_we),
        .o_dmem_addr         (o_dmem_addr),
        .o_dmem_wdata        (o_dmem_wdata),
        .i_dmem_ready        (i_dmem_ready),
        .i_dmem_rvalid       (i_dmem_rvalid),
        .i_dmem_rdata        (i_dmem_rdata),
        .o_WB_valid          (o_WB_valid),
        .o_WB_data_ALUOut    (o_WB_data_ALUOut),
        .o_WB_data_MemData   (o_WB_data_MemData),
        .o_WB_data_RegAddrW  (o_WB_data_RegAddrW),
        .o_WB_ctrl_Mem2Reg   (o_WB_ctrl_Mem2Reg),
        .o_WB_ctrl_RegWrite  (o_WB_ctrl_RegWrite),
        .o_exc_overflow      (o_exc_overflow),
        .o_exc_misalign      (o_exc_misalign),
        .o_exc_bus           (o_exc_bus)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        i_MEM_valid = 1'b0; i_MEM_data_ALUOut = '0; i_MEM_data_Overflow = 1'b0;
        i_MEM_data_RTData = '0; i_MEM_ctrl_MemRead = 1'b0; i_MEM_ctrl_MemWrite = 1'b0;
        i_WB_data_RegAddrW = '0; i_WB_ctrl_Mem2Reg = 1'b0; i_WB_ctrl_RegWrite = 1'b0;
    endtask

    task automatic drive_instr(input logic [31:0] alu, input logic ov, input logic [31:0] rt,
                               input logic rd_en, input logic wr_en, input logic [4:0] rd,
                               input logic m2r, input logic rw);
        i_MEM_valid = 1'b1; i_MEM_data_ALUOut = alu; i_MEM_data_Overflow = ov;
        i_MEM_data_RTData = rt; i_MEM_ctrl_MemRead = rd_en; i_MEM_ctrl_MemWrite = wr_en;
        i_WB_data_RegAddrW = rd; i_WB_ctrl_Mem2Reg = m2r; i_WB_ctrl_RegWrite = rw;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive_idle();
        i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        tick(); tick();
        rst = 1'b0; settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
        checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_dmem_req); end
        checks++; if ({o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_WB_data_RegAddrW} !== 8'h00) begin errors++; $display("FAIL reset_wb_ctrl: got %b%b%b %h expected all 0", o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg, o_WB_data_RegAddrW); end
        checks++; if ({o_WB_data_ALUOut, o_WB_data_MemData} !== 64'h0) begin errors++; $display("FAIL reset_wb_data: got %h %h expected 0 0", o_WB_data_ALUOut, o_WB_data_MemData); end
        checks++; if ({o_exc_overflow, o_exc_misalign, o_exc_bus} !== 3'b000) begin errors++; $display("FAIL reset_exc: got %b%b%b expected 000", o_exc_overflow, o_exc_misalign, o_exc_bus); end
    endtask

    task automatic test_alu();
        drive_instr(32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1); settle();
        checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b expected 0", o_stall); end
        tick(); drive_idle(); settle();
        checks++; if (o_WB_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid: got %b expected 1", o_WB_valid); end
        checks++; if (o_WB_data_ALUOut !== 32'h0000_1234) begin errors++; $display("FAIL alu_wb_aluout: got %h expected 00001234", o_WB_data_ALUOut); end
        checks++; if (o_WB_data_RegAddrW !== 5'd5 || o_WB_ctrl_RegWrite !== 1'b1) begin errors++; $display("FAIL alu_wb_rd: got rd=%0d rw=%b expected rd=5 rw=1", o_WB_data_RegAddrW, o_WB_ctrl_RegWrite); end
        tick();
        checks++; if (o_WB_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_drop: got %b expected 0", o_WB_valid); end
    endtask

    task automatic test_load();
        drive_instr(32'h0000_0100, 1'b0, 32'h0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1); settle();
        checks++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b0) begin errors++; $display("FAIL load_c0: got stall=%b req=%b expected stall=1 req=0", o_stall, o_dmem_req); end
        tick(); i_dmem_ready = 1'b1; settle();
        checks++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b1 || o_dmem_we !== 1'b0) begin errors++; $display("FAIL load_c1: got stall=%b req=%b we=%b expected 1 1 0", o_stall, o_dmem_req, o_dmem_we); end
        checks++; if (o_dmem_addr !== 30'h40) begin errors++; $display("FAIL load_addr: got %h expected 40", o_dmem_addr); end
        tick(); i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF; settle();
        checks++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b0) begin errors++; $display("FAIL load_c2: got stall=%b req=%b expected stall=1 req=0", o_stall, o_dmem_req); end
        tick(); i_dmem_rvalid = 1'b0; i_dmem_rdata = '0; settle();
        checks++; if (o_stall !== 1'b0 || o_WB_valid !== 1'b0) begin errors++; $display("FAIL load_c3: got stall=%b wb_valid=%b expected 0 0", o_stall, o_WB_valid); end
        tick(); drive_idle(); settle();
        checks++; if (o_WB_valid !== 1'b1 || o_WB_ctrl_RegWrite !== 1'b1 || o_WB_ctrl_Mem2Reg !== 1'b1) begin errors++; $display("FAIL load_c4_ctrl: got v=%b rw=%b m2r=%b expected 1 1 1", o_WB_valid, o_WB_ctrl_RegWrite, o_WB_ctrl_Mem2Reg); end
        checks++; if (o_WB_data_MemData !== 32'hDEAD_BEEF || o_WB_data_RegAddrW !== 5'd7) begin errors++; $display("FAIL load_c4_data: got mem=%h rd=%0d expected deadbeef 7", o_WB_data_MemData, o_WB_data_RegAddrW); end
        tick();
    endtask

    task automatic test_store_delayed();
        drive_instr(32'h0000_0008, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0); settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL store_c0_stall: got %b expected 1", o_stall); end
        for (int unsigned c = 1; c <= 3; c++) begin
            tick(); settle();
            checks++; if (o_dmem_req !== 1'b1 || o_stall !== 1'b1) begin errors++; $display("FAIL store_wait_c%0d: got req=%b stall=%b expected 1 1", c, o_dmem_req, o_stall); end
        end
        checks++; if (o_dmem_we !== 1'b1 || o_dmem_addr !== 30'h2 || o_dmem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL store_bus: got we=%b addr=%h wdata=%h expected 1 2 a5a5a5a5", o_dmem_we, o_dmem_addr, o_dmem_wdata); end
        tick(); i_dmem_ready = 1'b1; settle();
        checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL store_ready_req: got %b expected 1", o_dmem_req); end
        tick(); i_dmem_ready = 1'b0; settle();
        checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0 || o_WB_valid !== 1'b0) begin errors++; $display("FAIL store_done: got req=%b stall=%b wb_valid=%b expected 0 0 0", o_dmem_req, o_stall, o_WB_valid); end
        tick(); drive_idle(); settle();
        checks++; if (o_WB_valid !== 1'b1 || o_exc_bus !== 1'b0 || o_WB_data_ALUOut !== 32'h8) begin errors++; $display("FAIL store_wb: got v=%b bus=%b alu=%h expected 1 0 00000008", o_WB_valid, o_exc_bus, o_WB_data_ALUOut); end
        tick();
    endtask

    task automatic test_misalign();
        drive_instr(32'h0000_0102, 1'b0, 32'h0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1); settle();
        checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL mis_c0: got req=%b stall=%b expected 0 0", o_dmem_req, o_stall); end
        tick(); drive_idle(); settle();
        checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", o_dmem_req); end
        checks++; if ({o_WB_valid, o_exc_misalign, o_exc_overflow, o_WB_ctrl_RegWrite} !== 4'b1100) begin errors++; $display("FAIL mis_wb: got v/mis/ov/rw=%b%b%b%b expected 1100", o_WB_valid, o_exc_misalign, o_exc_overflow, o_WB_ctrl_RegWrite); end
        tick();
        checks++; if (o_exc_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", o_exc_misalign); end
    endtask

    task automatic test_overflow();
        drive_instr(32'h0000_0101, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1); settle();
        checks++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin errors++; $display("FAIL ov_c0: got stall=%b req=%b expected 0 0", o_stall, o_dmem_req); end
        tick(); drive_idle(); settle();
        checks++; if ({o_exc_overflow, o_exc_misalign, o_exc_bus, o_WB_ctrl_RegWrite} !== 4'b1000) begin errors++; $display("FAIL ov_wb: got ov/mis/bus/rw=%b%b%b%b expected 1000", o_exc_overflow, o_exc_misalign, o_exc_bus, o_WB_ctrl_RegWrite); end
        tick();
    endtask

    task automatic test_timeout();
        drive_instr(32'h0000_0200, 1'b0, 32'h0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
        tick(); i_dmem_ready = 1'b1;
        tick(); i_dmem_ready = 1'b0; settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL to_resp_stall: got %b expected 1", o_stall); end
        tick(); tick(); settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL to_last_stall: got %b expected 1", o_stall); end
        tick(); settle();
        checks++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin errors++; $display("FAIL to_done: got stall=%b req=%b expected 0 0", o_stall, o_dmem_req); end
        tick(); drive_idle(); i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h0000_0BAD; settle();
        checks++; if ({o_WB_valid, o_exc_bus, o_WB_ctrl_RegWrite, o_exc_overflow} !== 4'b1100) begin errors++; $display("FAIL to_wb: got v/bus/rw/ov=%b%b%b%b expected 1100", o_WB_valid, o_exc_bus, o_WB_ctrl_RegWrite, o_exc_overflow); end
        checks++; if (o_WB_data_MemData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_memdata: got %h expected deadbeef", o_WB_data_MemData); end
        tick(); i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        drive_instr(32'h0000_0055, 1'b0, 32'h0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1); settle();
        checks++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0 || o_exc_bus !== 1'b0) begin errors++; $display("FAIL to_idle: got stall=%b req=%b bus=%b expected 0 0 0", o_stall, o_dmem_req, o_exc_bus); end
        tick(); drive_idle(); settle();
        checks++; if (o_WB_data_MemData !== 32'hDEAD_BEEF || o_WB_data_ALUOut !== 32'h55) begin errors++; $display("FAIL to_late_rvalid: got mem=%h alu=%h expected deadbeef 00000055", o_WB_data_MemData, o_WB_data_ALUOut); end
        tick();
    endtask

    task automatic test_reset_resp();
        drive_instr(32'h0000_0300, 1'b0, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
        tick(); i_dmem_ready = 1'b1;
        tick(); i_dmem_ready = 1'b0; settle();
        checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL rr_in_resp: got stall=%b expected 1", o_stall); end
        rst = 1'b1; drive_idle();
        tick(); rst = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111; settle();
        checks++; if ({o_dmem_req, o_stall, o_WB_valid, o_WB_ctrl_RegWrite} !== 4'b0000) begin errors++; $display("FAIL rr_after_rst: got req/stall/v/rw=%b%b%b%b expected 0000", o_dmem_req, o_stall, o_WB_valid, o_WB_ctrl_RegWrite); end
        checks++; if (o_WB_data_MemData !== 32'h0 || o_WB_data_ALUOut !== 32'h0) begin errors++; $display("FAIL rr_wb_data: got mem=%h alu=%h expected 0 0", o_WB_data_MemData, o_WB_data_ALUOut); end
        tick(); i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        drive_instr(32'h0000_0300, 1'b0, 32'h0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
        tick(); i_dmem_ready = 1'b1; settle();
        checks++; if (o_dmem_req !== 1'b1 || o_dmem_addr !== 30'hC0) begin errors++; $display("FAIL rr_reissue_req: got req=%b addr=%h expected 1 c0", o_dmem_req, o_dmem_addr); end
        tick(); i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
        tick(); i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        tick(); drive_idle(); settle();
        checks++; if (o_WB_valid !== 1'b1 || o_WB_data_MemData !== 32'hCAFE_F00D || o_WB_ctrl_RegWrite !== 1'b1 || o_WB_data_RegAddrW !== 5'd9) begin errors++; $display("FAIL rr_reissue_wb: got v=%b mem=%h rw=%b rd=%0d expected 1 cafef00d 1 9", o_WB_valid, o_WB_data_MemData, o_WB_ctrl_RegWrite, o_WB_data_RegAddrW); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store_delayed();
        test_misalign();
        test_overflow();
        test_timeout();
        test_reset_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
